memory_responder: RTL and testbench

Single-port word memory that serves the core's memory request interface as the responder. It accepts fetch, load and store requests issued by the controller through the enable/command handshake and returns completion with read data after a fixed latency. The block sits between the controller/datapath and the backing storage, and replaces ideal test memories in the system bench.

---
 rtl/memory_responder.sv | 148 ++++++++++++++
 tb/tb_memory_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Fixed-latency single-port word memory answering enable/command requests.
// Completion is a one-cycle valid pulse; out-of-range word indices fault instead of aliasing.
module memory_responder #(
  parameter int    WORDS     = 4096,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_enable,
  input  logic        memory_command,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic        memory_ready,
  output logic        memory_valid,
  output logic [31:0] read_data,
  output logic        access_fault,
  output logic [1:0]  debug_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam int         AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [31:0] mem_q [WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cmd_q;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        fault_q;
  logic        ready_q;
  logic [31:0] rdata_q;

  logic        accept_s;
  logic        commit_s;
  logic        req_cmd_s;
  logic [29:0] req_idx_s;
  logic [31:0] req_wdata_s;
  logic [3:0]  req_mask_s;
  logic        req_fault_s;
  logic        unused_s;

  assign unused_s = ^address[1:0];

  // Next-state logic; with LATENCY=1 the commit happens on the acceptance edge,
  // so the request fields come straight from the inputs while still in IDLE.
  always_comb begin
    accept_s = (state_q == IDLE) && ready_q && memory_enable;
    if (state_q == IDLE) begin
      req_cmd_s   = memory_command;
      req_idx_s   = address[31:2];
      req_wdata_s = write_data;
      req_mask_s  = write_mask;
    end else begin
      req_cmd_s   = cmd_q;
      req_idx_s   = idx_q;
      req_wdata_s = wdata_q;
      req_mask_s  = mask_q;
    end
    req_fault_s = ({2'b00, req_idx_s} >= 32'(WORDS));
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESPOND : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESPOND;
        end else begin
          state_d = BUSY;
        end
      end
      RESPOND: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
    commit_s = !reset && (state_q != RESPOND) && (state_d == RESPOND);
  end

  // Control state, request capture and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      cmd_q   <= 1'b0;
      idx_q   <= 30'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      if (accept_s) begin
        cmd_q   <= memory_command;
        idx_q   <= address[31:2];
        wdata_q <= write_data;
        mask_q  <= write_mask;
        fault_q <= req_fault_s;
      end
      if (commit_s) begin
        if (req_fault_s) begin
          rdata_q <= 32'd0;
        end else if (!req_cmd_s) begin
          rdata_q <= mem_q[req_idx_s[AW-1:0]];
        end
      end
    end
  end

  // Byte-masked array write; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (commit_s && req_cmd_s && !req_fault_s) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask_s[b]) begin
          mem_q[req_idx_s[AW-1:0]][8*b +: 8] <= req_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign memory_ready = ready_q;
  assign memory_valid = (state_q == RESPOND);
  assign access_fault = (state_q == RESPOND) && fault_q;
  assign read_data    = rdata_q;
  assign debug_state  = state_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench: four responders (LATENCY 2,1,5,4; WORDS=16) share request buses, each with its own enable.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [3:0]  en;
  logic        ready_v [4];
  logic        valid_v [4];
  logic [31:0] rdata_v [4];
  logic        fault_v [4];
  logic [1:0]  state_v [4];

  int total = 0;
  int fails = 0;
  int lat;
  int k;
  int last_c;
  int vcount;
  logic [5:0] obs_valid;
  logic [5:0] obs_ready;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    memory_responder #(
      .WORDS(16),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 5 : 4),
      .INIT_FILE("")
    ) dut (
      .clk(clk),
      .reset(reset),
      .memory_enable(en[g]),
      .memory_command(cmd),
      .address(addr),
      .write_data(wdata),
      .write_mask(mask),
      .memory_ready(ready_v[g]),
      .memory_valid(valid_v[g]),
      .read_data(rdata_v[g]),
      .access_fault(fault_v[g]),
      .debug_state(state_v[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request to responder d and return at the negedge of its valid pulse.
  task automatic req(input int d, input logic c, input logic [31:0] a, input logic [31:0] dat,
                     input logic [3:0] m, output int l);
    for (int i = 0; i < 10 && !ready_v[d]; i++) @(negedge clk);
    cmd = c; addr = a; wdata = dat; mask = m; en[d] = 1'b1;
    @(negedge clk);
    en[d] = 1'b0; cmd = 1'bx; addr = 32'hxxxxxxxx; wdata = 32'hxxxxxxxx; mask = 4'hx;
    l = 1;
    for (int i = 0; i < 10 && !valid_v[d]; i++) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; en = 4'b0000; cmd = 1'b0; addr = 32'd0; wdata = 32'd0; mask = 4'd0;

    // Reset, then idle
    @(negedge clk);
    chk("rst_ready", 32'(ready_v[0]), 32'd0);
    chk("rst_valid", 32'(valid_v[0]), 32'd0);
    @(negedge clk);
    chk("rst_rdata", rdata_v[0], 32'h00000000);
    chk("rst_state", 32'(state_v[0]), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready_v[0]), 32'd1);
    chk("post_rst_valid", 32'(valid_v[0]), 32'd0);
    chk("post_rst_rdata", rdata_v[0], 32'h00000000);
    chk("post_rst_state", 32'(state_v[0]), 32'd0);

    // Preload word 3 and word 15 of responder 0
    req(0, 1'b1, 32'h0000000C, 32'hDEADBEEF, 4'hF, lat);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_fault", 32'(fault_v[0]), 32'd0);
    req(0, 1'b1, 32'h0000003C, 32'hCAFEF00D, 4'hF, lat);

    // Read with enable held high: valid 2 cycles after each acceptance
    @(negedge clk);
    cmd = 1'b0; addr = 32'h0000000C; en[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs_valid[i] = valid_v[0];
      obs_ready[i] = ready_v[0];
      if (valid_v[0]) chk("fetch_rdata", rdata_v[0], 32'hDEADBEEF);
    end
    en[0] = 1'b0;
    chk("fetch_valid_pattern", 32'(obs_valid), 32'(6'b010010));
    chk("fetch_ready_pattern", 32'(obs_ready), 32'(6'b100100));

    // Masked store then load; writes leave read_data untouched
    req(0, 1'b1, 32'h00000020, 32'h11223344, 4'b1111, lat);
    chk("st1_fault", 32'(fault_v[0]), 32'd0);
    chk("st1_rdata_held", rdata_v[0], 32'hDEADBEEF);
    req(0, 1'b1, 32'h00000020, 32'h0000AA00, 4'b0010, lat);
    chk("st2_fault", 32'(fault_v[0]), 32'd0);
    chk("st2_lat", 32'(lat), 32'd2);
    req(0, 1'b0, 32'h00000020, 32'h0, 4'h0, lat);
    chk("ld_merged", rdata_v[0], 32'h1122AA44);
    chk("ld_ready_in_valid", 32'(ready_v[0]), 32'd0);
    @(negedge clk);
    chk("ld_ready_after", 32'(ready_v[0]), 32'd1);
    chk("ld_valid_after", 32'(valid_v[0]), 32'd0);

    // Out-of-range accesses
    req(0, 1'b1, 32'h00000040, 32'hFFFFFFFF, 4'hF, lat);
    chk("oor_wr_lat", 32'(lat), 32'd2);
    chk("oor_wr_fault", 32'(fault_v[0]), 32'd1);
    chk("oor_wr_rdata", rdata_v[0], 32'h00000000);
    req(0, 1'b0, 32'h00000040, 32'h0, 4'h0, lat);
    chk("oor_rd_fault", 32'(fault_v[0]), 32'd1);
    chk("oor_rd_rdata", rdata_v[0], 32'h00000000);
    req(0, 1'b0, 32'h0000003C, 32'h0, 4'h0, lat);
    chk("w15_fault", 32'(fault_v[0]), 32'd0);
    chk("w15_rdata", rdata_v[0], 32'hCAFEF00D);

    // Zero mask write completes without changing the word
    req(0, 1'b1, 32'h0000003C, 32'h00000000, 4'b0000, lat);
    chk("nomask_lat", 32'(lat), 32'd2);
    req(0, 1'b0, 32'h0000003E, 32'h0, 4'h0, lat);
    chk("nomask_rdata", rdata_v[0], 32'hCAFEF00D);

    // Latency sweep with back-to-back reads on responders 1 (L=1) and 2 (L=5)
    for (int d = 1; d <= 2; d++) begin
      for (int w = 0; w < 4; w++) req(d, 1'b1, 32'(4 * w), 32'hC0DE0000 | 32'(w * 17), 4'hF, lat);
      @(negedge clk);
      k = 0; last_c = 0;
      cmd = 1'b0; addr = 32'd0; en[d] = 1'b1;
      for (int c = 1; c <= 40 && k < 4; c++) begin
        @(negedge clk);
        if (valid_v[d]) begin
          chk("b2b_rdata", rdata_v[d], 32'hC0DE0000 | 32'(k * 17));
          if (k == 0) chk("b2b_first", 32'(c), (d == 1) ? 32'd1 : 32'd5);
          else        chk("b2b_spacing", 32'(c - last_c), (d == 1) ? 32'd2 : 32'd6);
          last_c = c;
          k++;
          addr = 32'(4 * k);
          if (k == 4) en[d] = 1'b0;
        end
      end
      en[d] = 1'b0;
      chk("b2b_count", 32'(k), 32'd4);
    end

    // Reset in the middle of a LATENCY=4 write
    req(3, 1'b1, 32'h00000008, 32'h12345678, 4'hF, lat);
    chk("l4_lat", 32'(lat), 32'd4);
    @(negedge clk);
    cmd = 1'b1; addr = 32'h00000008; wdata = 32'h55555555; mask = 4'hF; en[3] = 1'b1;
    @(negedge clk);
    en[3] = 1'b0;
    chk("mid_busy", 32'(state_v[3]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", 32'(state_v[3]), 32'd0);
    chk("mid_rst_valid", 32'(valid_v[3]), 32'd0);
    reset = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_v[3]) vcount++;
    end
    chk("mid_no_valid", 32'(vcount), 32'd0);
    chk("mid_ready", 32'(ready_v[3]), 32'd1);
    req(3, 1'b0, 32'h00000008, 32'h0, 4'h0, lat);
    chk("mid_old_data", rdata_v[3], 32'h12345678);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
